// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared state, opcode and o_op encodings for the sequencing control unit
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_INDIRECT, ST_OPER, ST_EXEC, ST_WRITE, ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ADD, CLS_LDA, CLS_STA, CLS_BUN, CLS_ISZ, CLS_REG
  } op_class_e;

  localparam logic [2:0] OPC_ADD = 3'd1;
  localparam logic [2:0] OPC_LDA = 3'd2;
  localparam logic [2:0] OPC_STA = 3'd3;
  localparam logic [2:0] OPC_BUN = 3'd4;
  localparam logic [2:0] OPC_ISZ = 3'd6;
  localparam logic [2:0] OPC_REG = 3'd7;

  localparam int OP_ADD    = 0;
  localparam int OP_LOAD   = 1;
  localparam int OP_STORE  = 2;
  localparam int OP_BRANCH = 3;
  localparam int OP_ISZ    = 4;
  localparam int OP_REG    = 5;

  function automatic logic [5:0] op_onehot(op_class_e cls);
    logic [5:0] oh;
    oh = '0;
    case (cls)
      CLS_ADD: oh[OP_ADD]    = 1'b1;
      CLS_LDA: oh[OP_LOAD]   = 1'b1;
      CLS_STA: oh[OP_STORE]  = 1'b1;
      CLS_BUN: oh[OP_BRANCH] = 1'b1;
      CLS_ISZ: oh[OP_ISZ]    = 1'b1;
      CLS_REG: oh[OP_REG]    = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational split of an instruction word into class, indirect bit and address
module cu_decoder
  import cu_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
) (
  input  logic [DWIDTH-1:0] ir_i,
  output op_class_e         cls_o,
  output logic              ind_o,
  output logic [AWIDTH-1:0] addr_o
);

  logic unused_ir;

  always_comb begin
    cls_o = CLS_NOP;
    case (ir_i[DWIDTH-2:DWIDTH-4])
      OPC_ADD: cls_o = CLS_ADD;
      OPC_LDA: cls_o = CLS_LDA;
      OPC_STA: cls_o = CLS_STA;
      OPC_BUN: cls_o = CLS_BUN;
      OPC_ISZ: cls_o = CLS_ISZ;
      OPC_REG: cls_o = CLS_REG;
      default: cls_o = CLS_NOP;
    endcase
  end

  assign ind_o     = ir_i[DWIDTH-1];
  assign addr_o    = ir_i[AWIDTH-1:0];
  // Bits between the address and opcode fields carry no meaning here.
  assign unused_ir = ^ir_i;

endmodule

// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - fetch/decode/indirect/execute sequencer
// Optional memory-ack watchdog enabled by defining CU_TIMEOUT_EN.
module seq_control_unit
  import cu_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_halt,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [AWIDTH-1:0] o_mem_addr,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [DWIDTH-1:0] o_ir,
  output logic [AWIDTH-1:0] o_pc,
  output logic [5:0]        o_op,
  output logic              o_ex_start,
  input  logic              i_ex_done,
  input  logic              i_isz_skip,
  output logic              o_busy,
  output logic              o_err
);

  state_e            state_q;
  logic [AWIDTH-1:0] pc_q, ea_q, mem_addr_q;
  logic [DWIDTH-1:0] ir_q;
  logic [5:0]        op_q;
  logic              mem_req_q, mem_we_q, ex_start_q;
  logic              timeout_w;

  op_class_e         dec_cls;
  logic              dec_ind;
  logic [AWIDTH-1:0] dec_addr, pc_inc_d, ptr_d;

  cu_decoder #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_decoder (
    .ir_i   (ir_q),
    .cls_o  (dec_cls),
    .ind_o  (dec_ind),
    .addr_o (dec_addr)
  );

  assign pc_inc_d = pc_q + AWIDTH'(1);
  assign ptr_d    = i_mem_rdata[AWIDTH-1:0];

`ifdef CU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt_q;
  logic          err_q;

  assign timeout_w = mem_req_q && !i_mem_ack && (to_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (timeout_w) begin
      to_cnt_q <= '0;
      err_q    <= 1'b1;
    end else if (mem_req_q && !i_mem_ack) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
  assign o_err = err_q;
`else
  assign timeout_w = 1'b0;
  // Always 0; written against TIMEOUT so the parameter stays referenced.
  assign o_err = (TIMEOUT < 0);
`endif

  // Each request state spends one cycle with o_mem_req low before raising it,
  // which guarantees the request drops for at least one cycle after every ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ea_q       <= '0;
      op_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      ex_start_q <= 1'b0;
    end else begin
      ex_start_q <= 1'b0;
      if (timeout_w) begin
        state_q   <= ST_IDLE;
        mem_req_q <= 1'b0;
        op_q      <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (i_run && !o_err) state_q <= ST_FETCH;
          ST_FETCH: begin
            if (!mem_req_q) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= pc_q;
            end else if (i_mem_ack) begin
              mem_req_q <= 1'b0;
              ir_q      <= i_mem_rdata;
              pc_q      <= pc_inc_d;
              state_q   <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            ea_q <= dec_addr;
            op_q <= op_onehot(dec_cls);
            if (dec_cls == CLS_REG) begin
              state_q    <= ST_EXEC;
              ex_start_q <= 1'b1;
            end else if (dec_cls == CLS_NOP) begin
              state_q <= ST_DONE;
            end else if (dec_ind) begin
              state_q <= ST_INDIRECT;
            end else if (dec_cls == CLS_BUN) begin
              pc_q    <= dec_addr;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_OPER;
            end
          end
          ST_INDIRECT: begin
            if (!mem_req_q) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= ea_q;
            end else if (i_mem_ack) begin
              mem_req_q <= 1'b0;
              ea_q      <= ptr_d;
              if (dec_cls == CLS_BUN) begin
                pc_q    <= ptr_d;
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_OPER;
              end
            end
          end
          ST_OPER: begin
            if (!mem_req_q) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= (dec_cls == CLS_STA);
              mem_addr_q <= ea_q;
            end else if (i_mem_ack) begin
              mem_req_q <= 1'b0;
              if (dec_cls == CLS_STA) begin
                state_q <= ST_DONE;
              end else begin
                state_q    <= ST_EXEC;
                ex_start_q <= 1'b1;
              end
            end
          end
          ST_EXEC: begin
            // A done that coincides with the start pulse belongs to no operation.
            if (!ex_start_q && i_ex_done) begin
              if (dec_cls == CLS_ISZ) begin
                if (i_isz_skip) pc_q <= pc_inc_d;
                state_q <= ST_WRITE;
              end else begin
                state_q <= ST_DONE;
              end
            end
          end
          ST_WRITE: begin
            if (!mem_req_q) begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b1;
              mem_addr_q <= ea_q;
            end else if (i_mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= ST_DONE;
            end
          end
          ST_DONE: begin
            op_q    <= '0;
            state_q <= (i_halt || !i_run) ? ST_IDLE : ST_FETCH;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_mem_req  = mem_req_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_ir       = ir_q;
  assign o_pc       = pc_q;
  assign o_op       = op_q;
  assign o_ex_start = ex_start_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - randomized bench against an instruction-level reference model
module tb_seq_control_unit;

`ifdef CU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_run = 1'b0, i_halt = 1'b0;
  logic        o_mem_req, o_mem_we;
  logic [11:0] o_mem_addr;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic [15:0] o_ir;
  logic [11:0] o_pc;
  logic [5:0]  o_op;
  logic        o_ex_start, i_ex_done, i_isz_skip, o_busy, o_err;

  always #5 clk = ~clk;

  seq_control_unit #(.DWIDTH(16), .AWIDTH(12), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_halt(i_halt),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_ir(o_ir), .o_pc(o_pc), .o_op(o_op),
    .o_ex_start(o_ex_start), .i_ex_done(i_ex_done), .i_isz_skip(i_isz_skip),
    .o_busy(o_busy), .o_err(o_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem [0:4095];
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  logic        skip_q[$];
  int          fetch_cnt = 0;
  int          force_skip = -1;
  logic        mem_stall = 1'b0;
  logic [11:0] m_pc;
  logic [15:0] m_ir;

  // Event word: {is_exec, we, op, addr}
  function automatic logic [19:0] mk_ev(logic k, logic we, logic [5:0] op, logic [11:0] a);
    return {k, we, op, a};
  endfunction

  // Memory responder: random latency, stray acks while idle, address stability check.
  initial begin : mem_resp
    int wcnt;
    logic [11:0] a0;
    logic we0;
    wcnt = -1;
    a0 = '0;
    we0 = 1'b0;
    i_mem_ack = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_ack = 1'b0;
      i_mem_rdata = 16'($urandom);
      if (reset) begin
        wcnt = -1;
      end else if (o_mem_req) begin
        if (!mem_stall) begin
          if (wcnt < 0) begin
            wcnt = $urandom_range(0, 2);
            a0 = o_mem_addr;
            we0 = o_mem_we;
          end else begin
            check("req_stable", 32'({o_mem_we, o_mem_addr}), 32'({we0, a0}));
          end
          if (wcnt == 0) begin
            i_mem_ack = 1'b1;
            i_mem_rdata = mem[o_mem_addr];
            obs_q.push_back(mk_ev(1'b0, o_mem_we, o_op, o_mem_addr));
            if (o_op == 6'd0 && !o_mem_we) fetch_cnt++;
            wcnt = -1;
          end else begin
            wcnt--;
          end
        end
      end else begin
        wcnt = -1;
        if ($urandom_range(0, 7) == 0) i_mem_ack = 1'b1;
      end
    end
  end

  // Datapath responder: stray done pulses, including one coincident with the start pulse.
  initial begin : ex_resp
    int dcnt;
    dcnt = -1;
    i_ex_done = 1'b0;
    i_isz_skip = 1'b0;
    forever begin
      @(negedge clk);
      i_ex_done = 1'b0;
      i_isz_skip = 1'($urandom_range(0, 1));
      if (reset) begin
        dcnt = -1;
      end else if (o_ex_start) begin
        obs_q.push_back(mk_ev(1'b1, 1'b0, o_op, 12'd0));
        dcnt = $urandom_range(0, 3);
        i_ex_done = 1'($urandom_range(0, 1));
      end else if (dcnt == 0) begin
        if (force_skip >= 0) i_isz_skip = force_skip[0];
        i_ex_done = 1'b1;
        skip_q.push_back(i_isz_skip);
        dcnt = -1;
      end else if (dcnt > 0) begin
        dcnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        i_ex_done = 1'b1;
      end
    end
  end

  // Instruction-level reference: expected bus/execute events and architectural pc.
  task automatic model_instr();
    logic [15:0] w;
    logic [2:0]  opc;
    logic [11:0] ea;
    logic [5:0]  op;
    logic        sk;
    w = mem[m_pc];
    exp_q.push_back(mk_ev(1'b0, 1'b0, 6'd0, m_pc));
    m_pc = m_pc + 12'd1;
    m_ir = w;
    opc = w[14:12];
    ea = w[11:0];
    case (opc)
      3'd1: op = 6'b000001;
      3'd2: op = 6'b000010;
      3'd3: op = 6'b000100;
      3'd4: op = 6'b001000;
      3'd6: op = 6'b010000;
      3'd7: op = 6'b100000;
      default: op = 6'b000000;
    endcase
    if (op == 6'd0) return;
    if (opc != 3'd7) begin
      if (w[15]) begin
        exp_q.push_back(mk_ev(1'b0, 1'b0, op, ea));
        ea = mem[ea][11:0];
      end
      if (opc == 3'd4) begin
        m_pc = ea;
        return;
      end
      if (opc == 3'd3) begin
        exp_q.push_back(mk_ev(1'b0, 1'b1, op, ea));
        return;
      end
      exp_q.push_back(mk_ev(1'b0, 1'b0, op, ea));
    end
    exp_q.push_back(mk_ev(1'b1, 1'b0, op, 12'd0));
    check("ex_done_seen", 32'(skip_q.size() > 0), 32'd1);
    sk = (skip_q.size() > 0) ? skip_q.pop_front() : 1'b0;
    if (opc == 3'd6) begin
      if (sk) m_pc = m_pc + 12'd1;
      exp_q.push_back(mk_ev(1'b0, 1'b1, op, ea));
    end
  endtask

  task automatic run_instrs(input int k);
    int start, cyc;
    start = fetch_cnt;
    i_halt = 1'b0;
    i_run = 1'b1;
    cyc = 0;
    while (fetch_cnt < start + k && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check("fetch_wait", 32'(cyc < 4000), 32'd1);
    if ($urandom_range(0, 1) == 1) i_halt = 1'b1;
    else i_run = 1'b0;
    cyc = 0;
    while (o_busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    i_run = 1'b0;
    i_halt = 1'b0;
    check("idle_reached", 32'(o_busy), 32'd0);
    for (int j = 0; j < k; j++) model_instr();
    check("ev_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check("event", 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    check("pc", 32'(o_pc), 32'(m_pc));
    check("ir", 32'(o_ir), 32'(m_ir));
    check("op_idle", 32'(o_op), 32'd0);
    check("err_clear", 32'(o_err), 32'd0);
  endtask

  initial begin : main
    int cyc, nreq;
    logic any_busy;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h000] = 16'h2005;
    mem[12'h001] = 16'h9010;
    mem[12'h010] = 16'h0123;
    mem[12'h002] = 16'h4ABC;
    mem[12'hABC] = 16'h6020;
    mem[12'hABE] = 16'h6021;
    mem[12'hABF] = 16'h4FFF;
    mem[12'hFFF] = 16'h7800;

    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_pc", 32'(o_pc), 32'd0);
    check("rst_ir", 32'(o_ir), 32'd0);
    check("rst_op", 32'(o_op), 32'd0);
    check("rst_exs", 32'(o_ex_start), 32'd0);
    check("rst_addr", 32'({o_mem_we, o_mem_addr}), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    reset = 1'b0;
    m_pc = 12'd0;
    m_ir = 16'd0;

    run_instrs(1);
    check("lda_pc", 32'(o_pc), 32'h001);
    run_instrs(1);
    run_instrs(1);
    check("bun_pc", 32'(o_pc), 32'hABC);
    force_skip = 1;
    run_instrs(1);
    check("isz_skip_pc", 32'(o_pc), 32'hABE);
    force_skip = 0;
    run_instrs(1);
    check("isz_noskip_pc", 32'(o_pc), 32'hABF);
    force_skip = -1;
    run_instrs(2);
    check("pc_wrap", 32'(o_pc), 32'h000);

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int t = 0; t < 60; t++) run_instrs($urandom_range(1, 4));

    mem_stall = 1'b1;
    i_run = 1'b1;
    cyc = 0;
    while (!o_mem_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    #2 reset = 1'b1;
    #1;
    check("arst_req", 32'(o_mem_req), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_pc", 32'(o_pc), 32'd0);
    i_run = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    skip_q.delete();
    m_pc = 12'd0;
    run_instrs(3);

`ifdef CU_TIMEOUT_EN
    mem_stall = 1'b1;
    i_run = 1'b1;
    nreq = 0;
    cyc = 0;
    while (!o_err && cyc < 100) begin
      @(negedge clk);
      if (o_mem_req) nreq++;
      cyc++;
    end
    check("to_req_cycles", 32'(nreq), 32'(TO));
    check("to_err", 32'(o_err), 32'd1);
    check("to_busy", 32'(o_busy), 32'd0);
    check("to_req", 32'(o_mem_req), 32'd0);
    any_busy = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_busy = any_busy | o_busy;
    end
    check("to_run_ignored", 32'(any_busy), 32'd0);
    check("to_err_sticky", 32'(o_err), 32'd1);
    i_run = 1'b0;
    mem_stall = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("to_err_reset", 32'(o_err), 32'd0);
    reset = 1'b0;
    obs_q.delete();
    skip_q.delete();
`else
    nreq = 0;
    any_busy = 1'b0;
    check("no_timeout_err", 32'(o_err | any_busy | (nreq != 0)), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
